// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Pipelined two-operand adder/subtractor with valid/ready handshakes on both
// sides. The operands are cut into STAGES equal chunks of WIDTH/STAGES bits;
// stage k adds chunk k and registers its carry for stage k+1. The final stage
// registers the complete sum together with the carry, signed-overflow and
// zero flags, so every result field is valid exactly when out_valid is high.
//
// Subtraction is performed as a + ~b + 1. In that mode cin is ignored, and
// cout = 1 means "no borrow".
//
// Parameters
//   WIDTH   operand / sum width in bits. Must be divisible by STAGES.
//   STAGES  pipeline depth in cycles. WIDTH=1 is only legal with STAGES=1.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle (combinational)
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in, only used when sub=0
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   zero       1 when sum == 0
// -----------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // Bits handled by each stage.
    localparam int CW = WIDTH / STAGES;

    // The whole pipe moves as one shift register: it advances whenever the
    // output slot is empty or is being drained this cycle. A full stall
    // therefore freezes every stage, bubbles included.
    logic adv;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // -------------------------------------------------------------------------
    // Inter-stage links. Element k is the input of stage k: element 0 comes
    // from the ports, element k>0 from the registers of stage k-1.
    //   lk_a / lk_b : operand bits not yet consumed, right-aligned so that the
    //                 chunk to add next always sits in bits [CW-1:0]. lk_b
    //                 already carries the inversion for subtraction.
    //   lk_acc      : sum chunks produced by the earlier stages, in place.
    //   lk_cy       : carry into the chunk handled by this stage.
    // -------------------------------------------------------------------------
    logic             lk_vld [STAGES];
    logic [WIDTH-1:0] lk_a   [STAGES];
    logic [WIDTH-1:0] lk_b   [STAGES];
    logic [WIDTH-1:0] lk_acc [STAGES];
    logic             lk_cy  [STAGES];

    assign lk_vld[0] = in_valid;
    assign lk_a[0]   = a;
    assign lk_b[0]   = sub ? ~b : b;
    assign lk_acc[0] = '0;
    // The "+1" of two's-complement subtraction enters as the initial carry.
    assign lk_cy[0]  = sub | cin;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Chunk adder: CW bits plus one bit of carry out.
            logic [CW:0]      chunk_w;
            logic [WIDTH-1:0] acc_w;

            assign chunk_w = {1'b0, lk_a[gi][CW-1:0]}
                           + {1'b0, lk_b[gi][CW-1:0]}
                           + {{CW{1'b0}}, lk_cy[gi]};

            // Drop this stage's chunk into its slot of the running sum.
            always_comb begin
                acc_w              = lk_acc[gi];
                acc_w[gi*CW +: CW] = chunk_w[CW-1:0];
            end

            if (gi < STAGES - 1) begin : g_mid
                logic             vld_q, vld_d;
                logic [WIDTH-1:0] a_q, a_d;
                logic [WIDTH-1:0] b_q, b_d;
                logic [WIDTH-1:0] acc_q, acc_d;
                logic             cy_q, cy_d;

                always_comb begin
                    vld_d = lk_vld[gi];
                    // Shift out the consumed chunk; zeros fill from the top.
                    a_d   = lk_a[gi] >> CW;
                    b_d   = lk_b[gi] >> CW;
                    acc_d = acc_w;
                    cy_d  = chunk_w[CW];
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        vld_q <= 1'b0;
                        a_q   <= '0;
                        b_q   <= '0;
                        acc_q <= '0;
                        cy_q  <= 1'b0;
                    end else if (adv) begin
                        vld_q <= vld_d;
                        a_q   <= a_d;
                        b_q   <= b_d;
                        acc_q <= acc_d;
                        cy_q  <= cy_d;
                    end
                end

                assign lk_vld[gi+1] = vld_q;
                assign lk_a[gi+1]   = a_q;
                assign lk_b[gi+1]   = b_q;
                assign lk_acc[gi+1] = acc_q;
                assign lk_cy[gi+1]  = cy_q;
            end else begin : g_last
                logic             vld_q, vld_d;
                logic [WIDTH-1:0] sum_q, sum_d;
                logic             cout_q, cout_d;
                logic             ovf_q, ovf_d;
                logic             zero_q, zero_d;
                logic             msb_cin_w;

                // The carry into the MSB is recovered from the MSB sum bit:
                // s = a ^ b ^ c_in  =>  c_in = a ^ b ^ s.
                assign msb_cin_w = lk_a[gi][CW-1] ^ lk_b[gi][CW-1] ^ chunk_w[CW-1];

                always_comb begin
                    vld_d  = lk_vld[gi];
                    sum_d  = acc_w;
                    cout_d = chunk_w[CW];
                    ovf_d  = msb_cin_w ^ chunk_w[CW];
                    zero_d = (acc_w == '0);
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        vld_q  <= 1'b0;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        ovf_q  <= 1'b0;
                        zero_q <= 1'b0;
                    end else if (adv) begin
                        vld_q  <= vld_d;
                        sum_q  <= sum_d;
                        cout_q <= cout_d;
                        ovf_q  <= ovf_d;
                        zero_q <= zero_d;
                    end
                end

                assign out_valid = vld_q;
                assign sum       = sum_q;
                assign cout      = cout_q;
                assign ovf       = ovf_q;
                assign zero      = zero_q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//
// Two instances share clock and reset: an 8-bit single-stage adder and a
// 16-bit four-stage adder. Expected results come from a whole-word
// arithmetic model pushed into a per-instance queue at each input transfer
// and popped at each output transfer.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8;
    logic        cout8, ovf8, zero8;
    logic [7:0]  a8, b8, sum8;

    logic        in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16;
    logic        cout16, ovf16, zero16;
    logic [15:0] a16, b16, sum16;

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_first16 = -1;
    int out_first16 = -1;
    int out_last16  = -1;
    int out_cnt16   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    // Whole-word reference: a + b' + c' over w bits.
    function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic c, input logic s);
        exp_t        r;
        int unsigned mask, bb, full, sa, sb, ss;
        logic [15:0] nb;
        mask = (32'd1 << w) - 32'd1;
        nb   = ~bv;
        bb   = s ? ({16'h0, nb} & mask) : {16'h0, bv};
        full = {16'h0, av} + bb + ((s || c) ? 32'd1 : 32'd0);
        sa   = ({16'h0, av} >> (w - 1)) & 32'd1;
        sb   = (bb >> (w - 1)) & 32'd1;
        ss   = ((full & mask) >> (w - 1)) & 32'd1;
        r.sum  = 16'(full & mask);
        r.cout = ((full >> w) & 32'd1) != 0;
        r.ovf  = (sa == sb) && (ss != sa);
        r.zero = (full & mask) == 0;
        return r;
    endfunction

    // Scoreboards, sampled on the falling edge when everything is stable.
    always @(negedge clk) begin
        exp_t e8;
        if (!rst) begin
            if (out_valid8 && out_ready8) begin
                check_eq("sb8_has_entry", 32'(q8.size() != 0), 32'd1);
                if (q8.size() != 0) begin
                    e8 = q8.pop_front();
                    $display("out8  sum=%02h cout=%0b ovf=%0b zero=%0b", sum8, cout8, ovf8, zero8);
                    check_eq("sum8", 32'(sum8), 32'(e8.sum[7:0]));
                    check_eq("cout8", 32'(cout8), 32'(e8.cout));
                    check_eq("ovf8", 32'(ovf8), 32'(e8.ovf));
                    check_eq("zero8", 32'(zero8), 32'(e8.zero));
                end
            end
            if (in_valid8 && in_ready8)
                q8.push_back(model(8, {8'h0, a8}, {8'h0, b8}, cin8, sub8));
        end
    end

    always @(negedge clk) begin
        exp_t e16;
        if (!rst) begin
            if (out_valid16 && out_ready16) begin
                if (out_first16 < 0) out_first16 = cyc;
                out_last16 = cyc;
                out_cnt16++;
                check_eq("sb16_has_entry", 32'(q16.size() != 0), 32'd1);
                if (q16.size() != 0) begin
                    e16 = q16.pop_front();
                    $display("out16 sum=%04h cout=%0b ovf=%0b zero=%0b", sum16, cout16, ovf16, zero16);
                    check_eq("sum16", 32'(sum16), 32'(e16.sum));
                    check_eq("cout16", 32'(cout16), 32'(e16.cout));
                    check_eq("ovf16", 32'(ovf16), 32'(e16.ovf));
                    check_eq("zero16", 32'(zero16), 32'(e16.zero));
                end
            end
            if (in_valid16 && in_ready16) begin
                if (acc_first16 < 0) acc_first16 = cyc;
                q16.push_back(model(16, a16, b16, cin16, sub16));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One directed beat on the single-stage instance; result is due right
    // after the accepting edge.
    task automatic dir8(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s,
                        input logic [7:0] es, input logic ec, input logic eo, input logic ez,
                        input string tag);
        a8 = av; b8 = bv; cin8 = c; sub8 = s; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        check_eq({tag, "_valid"}, 32'(out_valid8), 32'd1);
        check_eq({tag, "_sum"}, 32'(sum8), 32'(es));
        check_eq({tag, "_cout"}, 32'(cout8), 32'(ec));
        check_eq({tag, "_ovf"}, 32'(ovf8), 32'(eo));
        check_eq({tag, "_zero"}, 32'(zero8), 32'(ez));
    endtask

    task automatic reset_trackers();
        acc_first16 = -1;
        out_first16 = -1;
        out_last16  = -1;
        out_cnt16   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        logic found;
        rst = 1'b1;
        in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; out_ready8 = 0;
        in_valid16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; out_ready16 = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid8", 32'(out_valid8), 32'd0);
        check_eq("rst_sum8", 32'(sum8), 32'd0);
        check_eq("rst_valid16", 32'(out_valid16), 32'd0);
        check_eq("rst_sum16", 32'(sum16), 32'd0);
        check_eq("rst_cout16", 32'(cout16), 32'd0);
        check_eq("rst_ovf16", 32'(ovf16), 32'd0);
        check_eq("rst_zero16", 32'(zero16), 32'd0);
        #2 rst = 1'b0;
        #1;
        check_eq("idle_in_ready8", 32'(in_ready8), 32'd1);
        check_eq("idle_in_ready16", 32'(in_ready16), 32'd1);
        tick();

        // Single-stage directed cases
        out_ready8 = 1'b1;
        dir8(8'd200, 8'd100, 1'b0, 1'b0, 8'd44,  1'b1, 1'b0, 1'b0, "t1");
        dir8(8'd5,   8'd7,   1'b0, 1'b1, 8'hFE,  1'b0, 1'b0, 1'b0, "t2a");
        dir8(8'h80,  8'd1,   1'b0, 1'b1, 8'h7F,  1'b1, 1'b1, 1'b0, "t2b");
        dir8(8'hFF,  8'd0,   1'b1, 1'b0, 8'h00,  1'b1, 1'b0, 1'b1, "t3a");
        dir8(8'd127, 8'd1,   1'b0, 1'b0, 8'd128, 1'b0, 1'b1, 1'b0, "t3b");
        tick();

        // Back-to-back sweep on the four-stage instance
        out_ready16 = 1'b1;
        reset_trackers();
        for (int i = 0; i < 64; i++) begin
            a16 = 16'(i >> 3); b16 = 16'(i & 7); cin16 = 0; sub16 = 0; in_valid16 = 1'b1;
            tick();
        end
        in_valid16 = 1'b0;
        for (int k = 0; k < 20 && out_cnt16 < 64; k++) tick();
        check_eq("sweep_count", 32'(out_cnt16), 32'd64);
        check_eq("sweep_latency", 32'(out_first16 - acc_first16), 32'd4);
        check_eq("sweep_contiguous", 32'(out_last16 - out_first16), 32'd63);

        // Carry across the chunk boundary
        a16 = 16'h00FF; b16 = 16'h0001; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            if (out_valid16) found = 1'b1;
        end
        check_eq("carry_cross_seen", 32'(found), 32'd1);
        check_eq("carry_cross_sum", 32'(sum16), 32'h0100);
        tick();

        // Stall with a full pipe
        for (int i = 0; i < 4; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
            in_valid16 = 1'b1;
            tick();
        end
        out_ready16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check_eq("stall_in_ready", 32'(in_ready16), 32'd0);
            check_eq("stall_valid", 32'(out_valid16), 32'd1);
            check_eq("stall_queue_depth", 32'(q16.size()), 32'd4);
            if (q16.size() != 0) begin
                check_eq("stall_sum", 32'(sum16), 32'(q16[0].sum));
                check_eq("stall_flags", {29'd0, cout16, ovf16, zero16},
                         {29'd0, q16[0].cout, q16[0].ovf, q16[0].zero});
            end
            tick();
        end
        out_ready16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        for (int k = 0; k < 12 && q16.size() != 0; k++) tick();
        check_eq("stall_drain", 32'(q16.size()), 32'd0);

        // Reset with operations in flight
        for (int i = 0; i < 4; i++) begin
            a16 = 16'($urandom_range(1, 16'h7FFF)); b16 = 16'($urandom_range(0, 255));
            cin16 = 0; sub16 = 0; in_valid16 = 1'b1;
            tick();
        end
        in_valid16 = 1'b0;
        check_eq("pre_rst_valid", 32'(out_valid16), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_valid", 32'(out_valid16), 32'd0);
        check_eq("async_rst_sum", 32'(sum16), 32'd0);
        q16.delete();
        q8.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("post_rst_idle", 32'(out_valid16), 32'd0);
        end
        tick();
        reset_trackers();
        a16 = 16'h1234; b16 = 16'h0F0F; cin16 = 1'b1; sub16 = 1'b0; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        for (int k = 0; k < 10 && out_cnt16 < 1; k++) tick();
        check_eq("post_rst_count", 32'(out_cnt16), 32'd1);
        check_eq("post_rst_latency", 32'(out_first16 - acc_first16), 32'd4);

        // Randomised traffic with back-pressure on both instances
        for (int k = 0; k < 400; k++) begin
            in_valid8   = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
            out_ready8  = ($urandom_range(0, 9) < 7);
            in_valid16  = ($urandom_range(0, 3) != 0);
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
            out_ready16 = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid8 = 1'b0; in_valid16 = 1'b0;
        out_ready8 = 1'b1; out_ready16 = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        check_eq("final_drain8", 32'(q8.size()), 32'd0);
        check_eq("final_drain16", 32'(q16.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined two-operand adder/subtractor. It is the sequential successor to the 8-bit ripple full adder.
- Operands are split into STAGES equal chunks; the carry is registered between chunks.
- Upstream and downstream use valid/ready handshakes.
- Produces sum, carry, signed overflow and zero flags for the CPU ALU datapath.

Parameters:
WIDTH, 8, operand and sum width in bits; must be divisible by STAGES.
STAGES, 1, pipeline depth in cycles; each stage adds a chunk of WIDTH/STAGES bits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand beat present.
in_ready  output  1  block accepts a beat this cycle.
a  input  WIDTH  operand A (unsigned/two's complement).
b  input  WIDTH  operand B.
cin  input  1  carry-in; used only when sub=0.
sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1 with cin ignored.
out_valid  output  1  result beat present.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result, modulo 2^WIDTH.
cout  output  1  carry out of MSB; for sub, 1 = no borrow.
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
zero  output  1  1 when sum == 0.

Behaviour:
- Reset (async, rst=1):
  - All stage valid bits clear; out_valid=0.
  - sum=0, cout=0, ovf=0, zero=0.
  - in_ready=1 while rst=0 and the pipe is empty.
  - An in-flight operation is discarded; nothing is emitted after reset release until new input arrives.
- Advance enable: adv = ~out_valid | out_ready.
  - in_ready = adv (combinational).
  - All stages shift together only when adv=1; a full stall holds every stage.
- Transfers:
  - Input transfer on clk edge when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Latency: exactly STAGES cycles from input transfer to out_valid when out_ready is held 1.
- Throughput: one result per cycle, with no bubbles when out_ready=1.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b' (b' = sub ? ~b : b) plus the carry from stage k-1.
  - Stage 0 uses cin' = sub ? 1 : cin.
  - Registers the chunk sum, carry and the remaining upper operand chunks.
  - Lower sum chunks already computed travel alongside.
- Last stage:
  - Registers the full sum and cout.
  - ovf comes from the MSB carry-in and carry-out; zero is computed from the final sum.
  - All flags are registered with sum, so they are valid exactly when out_valid=1.
- Bubbles: a stage holding no valid data still shifts when adv=1; its valid bit propagates as 0.
- Output stability: while out_valid=1 and out_ready=0, sum/cout/ovf/zero are held stable.
- Idle outputs: when out_valid=0, output values are don't-care but must not be X after reset.
- Simultaneous accept and emit with a full pipe and out_ready=1: both transfers occur in the same cycle.
- STAGES=1: single registered adder; latency 1.
- Width rules:
  - No sign extension; sum wraps modulo 2^WIDTH.
  - WIDTH=1 is legal only with STAGES=1.

Test Plan:
1. WIDTH=8, STAGES=1, sub=0, cin=0, a=200, b=100, out_ready=1 -> after 1 cycle out_valid=1, sum=44, cout=1, ovf=0 (signed -56+100=44), zero=0.
2. WIDTH=8, STAGES=1, sub=1, a=5, b=7 -> sum=8'hFE, cout=0 (borrow), ovf=0. Then a=8'h80, b=1, sub=1 -> sum=8'h7F, ovf=1, cout=1.
3. WIDTH=8, STAGES=1, a=8'hFF, b=0, cin=1, sub=0 -> sum=0, cout=1, zero=1, ovf=0. Then a=127, b=1, cin=0 -> sum=128, ovf=1.
4. WIDTH=16, STAGES=4, back-to-back:
   - Stimulus: an exhaustive sweep of a,b in 0..7 (64 beats, 64 consecutive in_valid cycles); out_ready=1.
   - Required: first out_valid exactly 4 cycles after the first accept; 64 consecutive results, in order, each sum=a+b.
   - Also a=16'h00FF, b=1 -> sum=16'h0100, proving the carry crosses the chunk boundary.
5. WIDTH=16, STAGES=4, stall:
   - Stimulus: fill the pipe with 4 ops, then drop out_ready for 5 cycles.
   - Required: in_ready=0 during the stall; out_valid=1 with sum/flags unchanged; no beat lost or duplicated after out_ready returns.
6. Reset mid-flight: WIDTH=16, STAGES=4, 3 ops in flight, assert rst asynchronously between clock edges -> out_valid=0 and sum=0 immediately; after release no stale result appears and the next op emerges after 4 cycles.
